// File: rtl/change_dispenser_if.sv
// change_dispenser_if: signal bundle between the vending FSM / hopper side and change_dispenser
interface change_dispenser_if;
    logic       vend_req;
    logic [2:0] refund_amt;
    logic       empty_one;
    logic       empty_half;
    logic       coin_sense;
    logic       fault_clr;
    logic       can_drv;
    logic       hop_one;
    logic       hop_half;
    logic [2:0] remaining;
    logic       busy;
    logic       done;
    logic       fault;
    modport master (
        output vend_req, refund_amt, empty_one, empty_half, coin_sense, fault_clr,
        input  can_drv, hop_one, hop_half, remaining, busy, done, fault
    );
    modport slave (
        input  vend_req, refund_amt, empty_one, empty_half, coin_sense, fault_clr,
        output can_drv, hop_one, hop_half, remaining, busy, done, fault
    );
endinterface

// File: rtl/change_dispenser.sv
// change_dispenser: can release then coin-by-coin change payout with sense confirm and timeout fault; RETRY_EN adds one re-eject per coin
module change_dispenser #(
    parameter int CAN_W   = 4,
    parameter int PULSE_W = 4,
    parameter int TIMEOUT = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    change_dispenser_if.slave bus
);
    typedef enum logic [2:0] {IDLE, VEND, SELECT, DRIVE, WAIT, DONE, FAULT} state_t;
    localparam logic [7:0] CAN_LAST     = 8'(CAN_W - 1);
    localparam logic [7:0] PULSE_LAST   = 8'(PULSE_W - 1);
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
    state_t     r_state, w_state_n;
    logic [7:0] r_t, w_t_n;
    logic [2:0] r_rem, w_rem_n;
    logic       r_coin, w_coin_n;
    logic       r_sensed, w_sensed_n;
    logic       w_sense_ok;
    logic       r_can, r_hop_one, r_hop_half, r_done, r_fault, r_busy;
`ifdef RETRY_EN
    logic       r_retry, w_retry_n;
`endif
    assign w_sense_ok = bus.coin_sense && !r_sensed && (r_state == DRIVE || r_state == WAIT);
    // next state, shared phase timer, owed amount and coin bookkeeping
    always_comb begin
        w_state_n  = r_state;
        w_t_n      = r_t + 8'd1;
        w_rem_n    = r_rem;
        w_coin_n   = r_coin;
        w_sensed_n = r_sensed;
`ifdef RETRY_EN
        w_retry_n  = r_retry;
`endif
        if (w_sense_ok) begin
            w_rem_n    = r_rem - (r_coin ? 3'd2 : 3'd1);
            w_sensed_n = 1'b1;
`ifdef RETRY_EN
            w_retry_n  = 1'b0;
`endif
        end
        case (r_state)
            IDLE: begin
                w_t_n = '0;
                if (bus.vend_req) begin
                    w_rem_n   = bus.refund_amt;
                    w_state_n = VEND;
                end
            end
            VEND: if (r_t == CAN_LAST) w_state_n = SELECT;
            SELECT: begin
                w_t_n      = '0;
                w_sensed_n = 1'b0;
`ifdef RETRY_EN
                w_retry_n  = 1'b0;
`endif
                w_coin_n   = r_rem >= 3'd2 && !bus.empty_one;
                w_state_n  = r_rem == 3'd0 ? DONE : (w_coin_n || !bus.empty_half) ? DRIVE : FAULT;
            end
            DRIVE: if (r_t == PULSE_LAST) w_state_n = (r_sensed || w_sense_ok) ? SELECT : WAIT;
            WAIT: begin
                if (w_sense_ok) w_state_n = SELECT;
                else if (r_t == TIMEOUT_LAST) begin
`ifdef RETRY_EN
                    if (!r_retry) begin
                        w_state_n = DRIVE;
                        w_t_n     = '0;
                        w_retry_n = 1'b1;
                    end else w_state_n = FAULT;
`else
                    w_state_n = FAULT;
`endif
                end
            end
            DONE: w_state_n = IDLE;
            FAULT: if (bus.fault_clr) begin
                w_state_n = IDLE;
                w_rem_n   = '0;
            end
            default: w_state_n = IDLE;
        endcase
    end
    // state and registered outputs decoded from the upcoming state
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state    <= IDLE;
            r_t        <= '0;
            r_rem      <= '0;
            r_coin     <= 1'b0;
            r_sensed   <= 1'b0;
            r_can      <= 1'b0;
            r_hop_one  <= 1'b0;
            r_hop_half <= 1'b0;
            r_done     <= 1'b0;
            r_fault    <= 1'b0;
            r_busy     <= 1'b0;
`ifdef RETRY_EN
            r_retry    <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_n;
            r_t        <= w_t_n;
            r_rem      <= w_rem_n;
            r_coin     <= w_coin_n;
            r_sensed   <= w_sensed_n;
            r_can      <= w_state_n == VEND;
            r_hop_one  <= w_state_n == DRIVE && w_coin_n;
            r_hop_half <= w_state_n == DRIVE && !w_coin_n;
            r_done     <= w_state_n == DONE;
            r_fault    <= w_state_n == FAULT;
            r_busy     <= w_state_n != IDLE;
`ifdef RETRY_EN
            r_retry    <= w_retry_n;
`endif
        end
    end
    assign bus.can_drv   = r_can;
    assign bus.hop_one   = r_hop_one;
    assign bus.hop_half  = r_hop_half;
    assign bus.remaining = r_rem;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.fault     = r_fault;
endmodule
